// File: rtl/dsp_rdata_ordered.sv
// rtl/dsp_rdata_ordered.sv - ordered R-channel dispatcher; define DSP_RDATA_OUTREG_EN for a registered skid output
module dsp_rdata_ordered #(
  parameter int SLV_AMT         = 4,
  parameter int DATA_WIDTH      = 32,
  parameter int TRANS_MST_ID_W  = 5,
  parameter int TRANS_RESP_W    = 2,
  parameter int SLV_ID_W        = (SLV_AMT > 1) ? $clog2(SLV_AMT) : 1,
  parameter int DSP_RDATA_DEPTH = 16,
  parameter int ORDER_DEPTH     = 8
) (
  input  logic                               ACLK_i,
  input  logic                               ARESET_i,
  input  logic [SLV_ID_W-1:0]                ord_slv_id_i,
  input  logic                               ord_valid_i,
  output logic                               ord_ready_o,
  input  logic [TRANS_MST_ID_W*SLV_AMT-1:0]  sa_RID_i,
  input  logic [DATA_WIDTH*SLV_AMT-1:0]      sa_RDATA_i,
  input  logic [TRANS_RESP_W*SLV_AMT-1:0]    sa_RRESP_i,
  input  logic [SLV_AMT-1:0]                 sa_RLAST_i,
  input  logic [SLV_AMT-1:0]                 sa_RVALID_i,
  output logic [SLV_AMT-1:0]                 sa_RREADY_o,
  output logic [TRANS_MST_ID_W-1:0]          m_RID_o,
  output logic [DATA_WIDTH-1:0]              m_RDATA_o,
  output logic [TRANS_RESP_W-1:0]            m_RRESP_o,
  output logic                               m_RLAST_o,
  output logic                               m_RVALID_o,
  input  logic                               m_RREADY_i,
  output logic [$clog2(ORDER_DEPTH):0]       outst_cnt_o
);
  localparam int BW  = TRANS_MST_ID_W + DATA_WIDTH + TRANS_RESP_W + 1;
  localparam int FAW = $clog2(DSP_RDATA_DEPTH);
  localparam int OAW = $clog2(ORDER_DEPTH);
  localparam int CW  = OAW + 1;

  typedef enum logic {IDLE, STREAM} state_t;

  // Per-slave beat FIFOs: beat = {rid, rdata, rresp, rlast}
  logic [BW-1:0]       fmem [SLV_AMT][DSP_RDATA_DEPTH];
  logic [FAW:0]        fwp  [SLV_AMT];
  logic [FAW:0]        frp  [SLV_AMT];
  logic [SLV_AMT-1:0]  f_full, f_empty, f_wr, f_rd;

  // Order queue of slave indices, one entry per outstanding burst
  logic [SLV_ID_W-1:0] oq [ORDER_DEPTH];
  logic [OAW:0]        oq_wp, oq_rp;
  logic [CW-1:0]       q_cnt;
  logic                q_full, q_push, q_pop;
  logic [SLV_ID_W-1:0] head;

  state_t              state_q, state_d;
  logic                mux_valid, mux_ready, beat_take;
  logic [BW-1:0]       mux_beat;

  assign q_cnt       = oq_wp - oq_rp;
  assign q_full      = (q_cnt == CW'(ORDER_DEPTH));
  assign ord_ready_o = ~q_full & ~ARESET_i;
  assign q_push      = ord_valid_i & ord_ready_o;
  assign head        = oq[oq_rp[OAW-1:0]];
  assign outst_cnt_o = q_cnt;

  assign mux_valid = (state_q == STREAM) & ~f_empty[head];
  assign mux_beat  = fmem[head][frp[head][FAW-1:0]];
  assign beat_take = mux_valid & mux_ready;
  assign q_pop     = beat_take & mux_beat[0];

  // FIFO status, slave-side handshakes and head-FIFO pop decode
  always_comb begin
    f_full  = '0;
    f_empty = '0;
    f_wr    = '0;
    f_rd    = '0;
    for (int i = 0; i < SLV_AMT; i++) begin
      f_empty[i] = (fwp[i] == frp[i]);
      f_full[i]  = (fwp[i][FAW] != frp[i][FAW]) && (fwp[i][FAW-1:0] == frp[i][FAW-1:0]);
      f_wr[i]    = sa_RVALID_i[i] & ~f_full[i] & ~ARESET_i;
      f_rd[i]    = beat_take & (head == SLV_ID_W'(i));
    end
  end

  assign sa_RREADY_o = ~f_full & {SLV_AMT{~ARESET_i}};

  // Beat storage; contents need no reset because pointers define validity
  always_ff @(posedge ACLK_i) begin
    for (int i = 0; i < SLV_AMT; i++) begin
      if (f_wr[i]) begin
        fmem[i][fwp[i][FAW-1:0]] <= {sa_RID_i[i*TRANS_MST_ID_W +: TRANS_MST_ID_W],
                                     sa_RDATA_i[i*DATA_WIDTH +: DATA_WIDTH],
                                     sa_RRESP_i[i*TRANS_RESP_W +: TRANS_RESP_W],
                                     sa_RLAST_i[i]};
      end
    end
  end

  // FIFO pointer advance
  always_ff @(posedge ACLK_i or posedge ARESET_i) begin
    if (ARESET_i) begin
      for (int i = 0; i < SLV_AMT; i++) begin
        fwp[i] <= '0;
        frp[i] <= '0;
      end
    end else begin
      for (int i = 0; i < SLV_AMT; i++) begin
        if (f_wr[i]) fwp[i] <= fwp[i] + 1'b1;
        if (f_rd[i]) frp[i] <= frp[i] + 1'b1;
      end
    end
  end

  // Order queue storage
  always_ff @(posedge ACLK_i) begin
    if (q_push) oq[oq_wp[OAW-1:0]] <= ord_slv_id_i;
  end

  // Order queue pointers; the head retires on the RLAST beat handshake
  always_ff @(posedge ACLK_i or posedge ARESET_i) begin
    if (ARESET_i) begin
      oq_wp <= '0;
      oq_rp <= '0;
    end else begin
      if (q_push) oq_wp <= oq_wp + 1'b1;
      if (q_pop)  oq_rp <= oq_rp + 1'b1;
    end
  end

  // Output FSM state register
  always_ff @(posedge ACLK_i or posedge ARESET_i) begin
    if (ARESET_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state: stream while any burst is queued, idle once the last one retires
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (q_push || (q_cnt != '0)) state_d = STREAM;
      STREAM:  if (q_pop && !q_push && (q_cnt == CW'(1))) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef DSP_RDATA_OUTREG_EN
  logic [BW-1:0] sk0, sk1;
  logic [1:0]    sk_cnt;
  logic          out_take;

  assign mux_ready  = (sk_cnt != 2'd2);
  assign out_take   = (sk_cnt != 2'd0) & m_RREADY_i;
  assign m_RVALID_o = (sk_cnt != 2'd0);
  assign {m_RID_o, m_RDATA_o, m_RRESP_o, m_RLAST_o} = sk0;

  // Two-entry skid: sk0 is the presented beat, sk1 catches one beat of backpressure
  always_ff @(posedge ACLK_i or posedge ARESET_i) begin
    if (ARESET_i) begin
      sk0    <= '0;
      sk1    <= '0;
      sk_cnt <= 2'd0;
    end else begin
      case ({beat_take, out_take})
        2'b10: begin
          if (sk_cnt == 2'd0) sk0 <= mux_beat;
          else                sk1 <= mux_beat;
          sk_cnt <= sk_cnt + 2'd1;
        end
        2'b01: begin
          sk0    <= (sk_cnt == 2'd2) ? sk1 : '0;
          sk_cnt <= sk_cnt - 2'd1;
        end
        2'b11: sk0 <= mux_beat;
        default: ;
      endcase
    end
  end
`else
  assign mux_ready  = m_RREADY_i;
  assign m_RVALID_o = mux_valid;
  assign {m_RID_o, m_RDATA_o, m_RRESP_o, m_RLAST_o} = mux_valid ? mux_beat : '0;
`endif

endmodule

// File: tb/tb_dsp_rdata_ordered.sv
// tb/tb_dsp_rdata_ordered.sv - randomized self-checking bench for dsp_rdata_ordered
module tb_dsp_rdata_ordered;
  typedef struct packed {
    logic [4:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  logic         clk;
  logic         rst;
  logic [1:0]   ord_slv_id;
  logic         ord_valid;
  logic         ord_ready;
  logic [19:0]  sa_rid;
  logic [127:0] sa_rdata;
  logic [7:0]   sa_rresp;
  logic [3:0]   sa_rlast;
  logic [3:0]   sa_rvalid;
  logic [3:0]   sa_rready;
  logic [4:0]   m_rid;
  logic [31:0]  m_rdata;
  logic [1:0]   m_rresp;
  logic         m_rlast;
  logic         m_rvalid;
  logic         m_rready;
  logic [3:0]   outst;

  dsp_rdata_ordered dut (
    .ACLK_i(clk), .ARESET_i(rst),
    .ord_slv_id_i(ord_slv_id), .ord_valid_i(ord_valid), .ord_ready_o(ord_ready),
    .sa_RID_i(sa_rid), .sa_RDATA_i(sa_rdata), .sa_RRESP_i(sa_rresp),
    .sa_RLAST_i(sa_rlast), .sa_RVALID_i(sa_rvalid), .sa_RREADY_o(sa_rready),
    .m_RID_o(m_rid), .m_RDATA_o(m_rdata), .m_RRESP_o(m_rresp), .m_RLAST_o(m_rlast),
    .m_RVALID_o(m_rvalid), .m_RREADY_i(m_rready), .outst_cnt_o(outst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_errors = 0;
  beat_t      sq [4][$];
  beat_t      exp_q[$];
  logic [1:0] push_q[$];
  int         mcnt = 0;
  logic [3:0] s_en = 4'h0;
  logic [3:0] last_acc = 4'h0;
  int         gap_pct = 0;
  int         push_pct = 100;
  int         rmode = 1;
  bit         hold_pend = 0;
  beat_t      held;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic add_burst(input int s, input int len, input bit do_push);
    beat_t       b;
    logic [31:0] r;
    logic [4:0]  id;
    r  = $urandom;
    id = r[4:0];
    for (int k = 0; k < len; k++) begin
      r      = $urandom;
      b.id   = id;
      b.data = $urandom;
      b.resp = r[1:0];
      b.last = (k == len - 1);
      sq[s].push_back(b);
      exp_q.push_back(b);
    end
    if (do_push) push_q.push_back(2'(s));
  endtask

  // One clock: observe at the falling edge, then drive after the rising edge
  task automatic step();
    logic [3:0] acc;
    logic       pacc;
    beat_t      got;
    beat_t      e;
    @(negedge clk);
    acc  = sa_rvalid & sa_rready;
    pacc = ord_valid & ord_ready;
    last_acc = acc;
    chk("outst_cnt", outst, mcnt);
    chk("ord_ready", ord_ready, mcnt != 8);
    got = {m_rid, m_rdata, m_rresp, m_rlast};
    if (hold_pend) begin
      chk("hold_valid", m_rvalid, 1);
      chk("hold_beat", got, held);
    end
    hold_pend = 0;
    if (m_rvalid) begin
      if (m_rready) begin
        if (exp_q.size() == 0) chk("extra_beat", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("beat", got, e);
          if (e.last) mcnt--;
        end
      end else begin
        hold_pend = 1;
        held = got;
      end
    end else begin
      chk("idle_zero", got, 0);
    end
    if (pacc) mcnt++;
    @(posedge clk);
    #1;
    if (pacc) void'(push_q.pop_front());
    if (!(ord_valid && !pacc)) begin
      if (push_q.size() > 0 && $urandom_range(99) < push_pct) begin
        ord_valid  = 1'b1;
        ord_slv_id = push_q[0];
      end else ord_valid = 1'b0;
    end
    for (int s = 0; s < 4; s++) begin
      if (acc[s]) void'(sq[s].pop_front());
      if (!(sa_rvalid[s] && !acc[s])) begin
        if (s_en[s] && sq[s].size() > 0 && $urandom_range(99) >= gap_pct) begin
          sa_rvalid[s]        = 1'b1;
          sa_rid[s*5 +: 5]    = sq[s][0].id;
          sa_rdata[s*32 +: 32] = sq[s][0].data;
          sa_rresp[s*2 +: 2]  = sq[s][0].resp;
          sa_rlast[s]         = sq[s][0].last;
        end else sa_rvalid[s] = 1'b0;
      end
    end
    case (rmode)
      0:       m_rready = 1'b0;
      1:       m_rready = 1'b1;
      2:       m_rready = ($urandom_range(99) < 60);
      default: m_rready = ~m_rready;
    endcase
  endtask

  task automatic drain(input int lim);
    int c;
    c = 0;
    while ((exp_q.size() > 0 || push_q.size() > 0) && c < lim) begin
      step();
      c++;
    end
    chk("drain_done", exp_q.size(), 0);
  endtask

  initial begin
    int cyc;
    rst = 1'b1; ord_slv_id = '0; ord_valid = 1'b0;
    sa_rid = '0; sa_rdata = '0; sa_rresp = '0; sa_rlast = '0; sa_rvalid = '0;
    m_rready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rvalid", m_rvalid, 0);
    chk("rst_sa_rready", sa_rready, 4'h0);
    chk("rst_ord_ready", ord_ready, 0);
    chk("rst_outst", outst, 0);
    rst = 1'b0;
    step(); step();
    chk("post_rst_sa_rready", sa_rready, 4'hF);

    // Slave 0 delivers first, but slave 2's burst was ordered first
    gap_pct = 0; push_pct = 100; rmode = 1; s_en = 4'b0001;
    add_burst(2, 2, 1);
    add_burst(0, 4, 1);
    repeat (12) step();
    chk("head_waits_for_slave2", m_rvalid, 0);
    s_en = 4'hF;
    drain(60);

    // Fill the order queue with no data available
    s_en = 4'h0;
    for (int i = 0; i < 8; i++) add_burst(i % 4, 1, 1);
    repeat (12) step();
    chk("queue_full_ready", ord_ready, 0);
    chk("queue_full_cnt", outst, 8);
    s_en = 4'b0001;
    cyc = 0;
    while (outst != 4'd7 && cyc < 20) begin step(); cyc++; end
    chk("after_retire_ready", ord_ready, 1);
    chk("after_retire_cnt", outst, 7);
    s_en = 4'hF;
    drain(100);

    // Slave 1 fills its FIFO before any order entry exists
    rmode = 0; s_en = 4'b0010;
    add_burst(1, 16, 0);
    repeat (24) step();
    chk("fifo_full_rready", sa_rready[1], 0);
    chk("no_order_no_valid", m_rvalid, 0);
    push_q.push_back(2'd1);
    rmode = 1;
    drain(100);

    // Master ready toggling on a 4-beat burst
    rmode = 3; s_en = 4'hF;
    add_burst(3, 4, 1);
    drain(60);

    // Latency from FIFO write to valid with the burst already at the head
    rmode = 0; s_en = 4'h0;
    add_burst(2, 1, 1);
    cyc = 0;
    while (mcnt != 1 && cyc < 10) begin step(); cyc++; end
    s_en = 4'b0100;
    cyc = 0;
    last_acc = 4'h0;
    while (!last_acc[2] && cyc < 10) begin step(); cyc++; end
    chk("write_seen", last_acc[2], 1);
`ifdef DSP_RDATA_OUTREG_EN
    chk("latency_first_edge", m_rvalid, 0);
    @(posedge clk);
    #1;
`endif
    chk("latency_valid", m_rvalid, 1);
    rmode = 1;
    drain(40);

    // Randomized traffic against the scoreboard
    gap_pct = 30; push_pct = 70; rmode = 2; s_en = 4'hF;
    for (int b = 0; b < 80; b++) add_burst($urandom_range(3), $urandom_range(1, 8), 1);
    drain(20000);
    repeat (3) step();

    // Reset in the middle of a burst
    rmode = 0; gap_pct = 0; push_pct = 100;
    add_burst(1, 4, 1);
    cyc = 0;
    while (!m_rvalid && cyc < 20) begin step(); cyc++; end
    chk("mid_burst_valid", m_rvalid, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_rvalid", m_rvalid, 0);
    chk("mid_rst_sa_rready", sa_rready, 4'h0);
    chk("mid_rst_outst", outst, 0);
    chk("mid_rst_ord_ready", ord_ready, 0);
    for (int s = 0; s < 4; s++) sq[s].delete();
    exp_q.delete();
    push_q.delete();
    sa_rvalid = '0; ord_valid = 1'b0; mcnt = 0; hold_pend = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rel_sa_rready", sa_rready, 4'hF);
    chk("rel_outst", outst, 0);
    chk("rel_rvalid", m_rvalid, 0);
    repeat (2) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
